logic_gate_unit: RTL
====================

# logic_gate_unit

Parametrised, registered bitwise logic unit that succeeds the fixed 8-bit AND gate in the gate library. It applies a selectable two-input logic function to WIDTH-bit operands, can also fold a burst of operands into one result (accumulate mode), and delivers results through a valid/ready output buffer of configurable depth. It sits between a streaming producer and consumer as the library's general-purpose gate stage.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- DEPTH, 2, output buffer entries (≥1)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a beat
- in_ready  out  1  unit accepts a beat this cycle
- op  in  3  function select (sampled per accepted beat; in a burst, first beat only)
- acc_mode  in  1  1 = beat belongs to an accumulate burst (sampled on first beat)
- in_last  in  1  final beat of an accumulate burst (ignored when acc_mode=0)
- in1  in  WIDTH  operand A
- in2  in  WIDTH  operand B
- out_valid  out  1  buffer head valid
- out_ready  in  1  consumer takes head this cycle
- out  out  WIDTH  result at buffer head
- out_zero  out  1  head result is all zeros
- out_ones  out  1  head result is all ones

## Operation
- Beat accepted when in_valid && in_ready; out popped when out_valid && out_ready.
- op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT in1 (in2 ignored), 7 PASS in1. Pure bitwise, no carries; result width = WIDTH.
- Single mode (acc_mode=0 on accepted beat in IDLE): result = op(in1,in2) pushed to buffer.
- Accumulate FSM, states IDLE, ACCUM:
  - IDLE, accepted beat, acc_mode=1, in_last=0: acc ← op(in1,in2), latch op → ACCUM.
  - IDLE, accepted beat, acc_mode=1, in_last=1: one-beat burst; push op(in1,in2), stay IDLE.
  - ACCUM, accepted beat, in_last=0: acc ← op_latched(acc,in1); in2, op, acc_mode ignored.
  - ACCUM, accepted beat, in_last=1: push op_latched(acc,in1) → IDLE.
  - Only the final result of a burst is pushed; intermediate beats produce no output.
- out_zero/out_ones computed from the stored head entry (stored with entry, not recomputed from live inputs); both 0 when out_valid=0.
- in_ready = buffer not full (count < DEPTH), in every state, including for non-last burst beats.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out=0, out_zero=0, out_ones=0, buffer count=0, FSM=IDLE, acc=0; in_ready=1 once count=0.
- Latency: result of a pushing beat accepted at edge N visible on out/out_valid after edge N (one cycle). Throughput one beat/cycle while not full.
- Buffer full: in_ready=0; no pass-through, so a pop in a full cycle raises in_ready only from the next cycle.
- Simultaneous push and pop with count in 1..DEPTH-1: count unchanged, order preserved (FIFO).
- out held stable while out_valid=1 and out_ready=0.
- Reset mid-burst: partial acc discarded, FSM to IDLE, buffered results lost.
- Wrap-around: buffer pointers wrap modulo DEPTH; DEPTH need not be a power of two.

## Structure
- Package logic_gate_pkg: op encoding constants (OP_AND … OP_PASS), FSM state type (IDLE, ACCUM), function applying op to two vectors.
- Sub-module logic_gate_fifo: parametrised WIDTH+2 (result, zero, ones) × DEPTH synchronous FIFO with count, full, empty; top holds FSM, accumulator, op latch.

## Test plan
- Single AND, WIDTH=8: in1=0x33, in2=0xCC → out=0x00, out_zero=1; then in1=0xAA, in2=0xF0 → out=0xA0, both flags 0, one cycle after each accept.
- All ops on in1=0xAA, in2=0xF0: AND 0xA0, OR 0xFA, XOR 0x5A, NAND 0x5F, NOR 0x05, XNOR 0xA5, NOT 0x55, PASS 0xAA; OR of 0x0F/0xF0 → 0xFF, out_ones=1.
- Accumulate XOR burst: (0x01,0x02), 0x04, 0x08 with last → single out=0x0F; no out_valid during burst; op changed mid-burst has no effect.
- Backpressure, DEPTH=2: out_ready=0, push 3 single beats → in_ready drops after 2nd, 3rd held; release out_ready → results emitted in order, 3rd accepted afterwards.
- Reset mid-burst: start AND burst with 0xFF,0x0F, assert rst_n=0 mid-cycle → out_valid=0 immediately; after release single OR 0x10/0x01 → out=0x11.
- WIDTH=32, DEPTH=3: XNOR 0xFFFF0000/0xFFFF0000 → 0xFFFFFFFF, out_ones=1; simultaneous push/pop at count=1 keeps count=1.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate unit: op encoding, accumulate FSM
// states and the per-bit logic function used by both operand paths.
package logic_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Single-bit form keeps the function width-agnostic; callers loop over WIDTH.
    function automatic logic apply_op_bit(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_NOT:  r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_fifo.sv
// Synchronous FIFO holding result entries; pointers wrap modulo DEPTH so any
// DEPTH >= 1 works, not only powers of two. No read-through: a pop in a full
// cycle frees space only from the next cycle.
module logic_gate_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Next pointer and occupancy; push and pop together leave count unchanged.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written on accepted push.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count/empty guard every read of it.
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit: single-beat results or a folded accumulate
// burst, delivered through a valid/ready output buffer.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             in_last,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_zero,
    output logic             out_ones
);

    localparam int ENTRY_W = WIDTH + 2;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   single_res;
    logic [WIDTH-1:0]   burst_res;
    logic [WIDTH-1:0]   push_res;
    logic               push;
    logic               accept;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] head;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;

    // Candidate results: first beat applies op to in1/in2, continuing beats fold in1 into acc.
    always_comb begin
        single_res = '0;
        burst_res  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            single_res[i] = apply_op_bit(op, in1[i], in2[i]);
            burst_res[i]  = apply_op_bit(op_q, acc_q[i], in1[i]);
        end
    end

    // State, accumulator and latched burst op; reset drops any partial burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= OP_AND;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
        end
    end

    // Next state: enter ACCUM on a non-last burst opener, leave on the last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && acc_mode && !in_last) state_d = ACCUM;
            ACCUM:   if (accept && in_last)              state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath control: what gets pushed and how the accumulator evolves.
    always_comb begin
        push     = 1'b0;
        push_res = single_res;
        acc_d    = acc_q;
        op_d     = op_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (acc_mode && !in_last) begin
                        acc_d = single_res;
                        op_d  = op;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (in_last) begin
                        push     = 1'b1;
                        push_res = burst_res;
                    end else begin
                        acc_d = burst_res;
                    end
                end
            end
            default: ;
        endcase
    end

    // Flags travel with the entry so they always describe the stored head result.
    logic_gate_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({push_res, ~|push_res, &push_res}),
        .pop     (out_ready),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out       = fifo_empty ? '0 : head[ENTRY_W-1:2];
    assign out_zero  = !fifo_empty && head[1];
    assign out_ones  = !fifo_empty && head[0];

    count_in_range: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= CNT_W'(DEPTH));

endmodule
